// File: rtl/calculadora_seq.sv
// Sequential calculator: one-cycle ALU ops, WIDTH-cycle shift-add multiply, accumulate into saida.
// Latency 1 cycle (EXEC) or WIDTH cycles (MUL). inicio is ignored while ocupado=1.
module calculadora_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] entrada_A,
    input  logic [WIDTH-1:0] entrada_B,
    input  logic [2:0]       codigo,
    input  logic             inicio,
    output logic [WIDTH-1:0] saida,
    output logic             pronto,
    output logic             ocupado,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             erro
);
    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_r, b_r, mplier;
    logic [2:0]         cod_r;
    logic [CW-1:0]      cnt;
    logic               last;
    logic [2*WIDTH-1:0] mcand, prod, prod_sum;
    logic [WIDTH:0]     add_ext, sub_ext, acc_ext;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_o;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ocupado   = (state != IDLE);
        case (state)
            IDLE:    if (inicio) state_nxt = (codigo == 3'b101) ? MUL : EXEC;
            EXEC:    state_nxt = IDLE;
            MUL:     if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops; accumulate reads saida, which cannot change while busy.
    always_comb begin
        add_ext  = {1'b0, a_r} + {1'b0, b_r};
        sub_ext  = {1'b0, a_r} - {1'b0, b_r};
        acc_ext  = {1'b0, saida} + {1'b0, a_r};
        prod_sum = prod + (mplier[0] ? mcand : '0);
        res      = '0;
        res_c    = 1'b0;
        res_o    = 1'b0;
        case (cod_r)
            3'b001: res = a_r;
            3'b010: res = b_r;
            3'b011: begin
                res   = add_ext[WIDTH-1:0];
                res_c = add_ext[WIDTH];
                res_o = (a_r[MSB] == b_r[MSB]) && (res[MSB] != a_r[MSB]);
            end
            3'b100: begin
                res   = sub_ext[WIDTH-1:0];
                res_c = sub_ext[WIDTH];
                res_o = (a_r[MSB] != b_r[MSB]) && (res[MSB] != a_r[MSB]);
            end
            3'b110: begin
                res   = acc_ext[WIDTH-1:0];
                res_c = acc_ext[WIDTH];
                res_o = (saida[MSB] == a_r[MSB]) && (res[MSB] != saida[MSB]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            cod_r    <= '0;
            mplier   <= '0;
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
            saida    <= '0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            pronto   <= 1'b0;
            erro     <= 1'b0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            case (state)
                IDLE: if (inicio) begin
                    a_r    <= entrada_A;
                    b_r    <= entrada_B;
                    cod_r  <= codigo;
                    prod   <= '0;
                    mcand  <= {{WIDTH{1'b0}}, entrada_A};
                    mplier <= entrada_B;
                    cnt    <= '0;
                end
                EXEC: begin
                    pronto <= 1'b1;
                    if (cod_r == 3'b111) begin
                        erro <= 1'b1;
                    end else begin
                        saida    <= res;
                        carry    <= res_c;
                        overflow <= res_o;
                        zero     <= (res == '0);
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle; the final partial sum is written directly.
                    prod   <= prod_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        pronto   <= 1'b1;
                        saida    <= prod_sum[WIDTH-1:0];
                        carry    <= |prod_sum[2*WIDTH-1:WIDTH];
                        overflow <= 1'b0;
                        zero     <= (prod_sum[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calculadora_seq.sv
// Directed bench for calculadora_seq (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_calculadora_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] entrada_A, entrada_B;
    logic [2:0] codigo;
    logic       inicio;
    logic [7:0] saida;
    logic       pronto, ocupado, carry, zero, overflow, erro;

    int total = 0;
    int bad   = 0;

    calculadora_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .entrada_A(entrada_A), .entrada_B(entrada_B),
        .codigo(codigo), .inicio(inicio), .saida(saida), .pronto(pronto),
        .ocupado(ocupado), .carry(carry), .zero(zero), .overflow(overflow), .erro(erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] cod;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        logic       z;
        logic       o;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_saida", saida, 0);
        check("rst_zero", zero, 1);
        check("rst_flags", {pronto, ocupado, carry, overflow, erro}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        codigo = c; entrada_A = a; entrada_B = b; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
    endtask

    // Counts edges until pronto and cycles with ocupado high before it.
    task automatic wait_pronto(output int lat, output int busy);
        lat  = -1;
        busy = 0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            if (ocupado) busy++;
            @(posedge clk);
            #1;
            if (pronto) lat = i;
        end
    endtask

    initial begin
        int lat, busy, seen;
        vecs[0]  = '{1'b0, 3'b011, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 3'b100, 8'd5,   8'd7,   8'd254, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b0, 3'b100, 8'd128, 8'd1,   8'd127, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{1'b0, 3'b101, 8'd13,  8'd11,  8'd143, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        vecs[4]  = '{1'b0, 3'b101, 8'd16,  8'd16,  8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8};
        vecs[5]  = '{1'b0, 3'b000, 8'd55,  8'd66,  8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{1'b0, 3'b001, 8'd77,  8'd3,   8'd77,  1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 3'b010, 8'd77,  8'd3,   8'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 3'b011, 8'd127, 8'd1,   8'd128, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{1'b1, 3'b110, 8'd100, 8'd0,   8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 3'b110, 8'd100, 8'd0,   8'd200, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b0, 3'b110, 8'd56,  8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[12] = '{1'b0, 3'b111, 8'd1,   8'd2,   8'd0,   1'b1, 1'b1, 1'b0, 1'b1, 1};
        vecs[13] = '{1'b0, 3'b101, 8'd255, 8'd255, 8'd1,   1'b1, 1'b0, 1'b0, 1'b0, 8};

        rst_n = 1'b0; inicio = 1'b0; codigo = '0; entrada_A = '0; entrada_B = '0;
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            start_op(vecs[i].cod, vecs[i].a, vecs[i].b);
            wait_pronto(lat, busy);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), busy, vecs[i].lat);
            check($sformatf("v%0d_ocupado_at_pronto", i), ocupado, 0);
            check($sformatf("v%0d_saida", i), saida, vecs[i].s);
            check($sformatf("v%0d_carry", i), carry, vecs[i].c);
            check($sformatf("v%0d_zero", i), zero, vecs[i].z);
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].o);
            check($sformatf("v%0d_erro", i), erro, vecs[i].e);
        end

        // inicio pulsed with an add in the middle of a multiply is ignored
        start_op(3'b101, 8'd13, 8'd11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        codigo = 3'b011; entrada_A = 8'd1; entrada_B = 8'd1; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        wait_pronto(lat, busy);
        check("midmul_lat", lat, 4);
        check("midmul_saida", saida, 143);
        check("midmul_carry", carry, 0);
        @(posedge clk);
        #1;
        check("midmul_no_extra_op", {pronto, ocupado}, 0);

        // reset during multiply aborts it with no pronto
        start_op(3'b101, 8'd13, 8'd11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_saida", saida, 0);
        check("abort_zero", zero, 1);
        check("abort_flags", {pronto, ocupado, carry, overflow, erro}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (pronto || ocupado) seen++;
        end
        check("abort_no_pronto", seen, 0);
        check("abort_saida_kept", saida, 0);

        start_op(3'b001, 8'd9, 8'd0);
        wait_pronto(lat, busy);
        check("load9_lat", lat, 1);
        check("load9_saida", saida, 9);

        // invalid code leaves result and flags untouched, erro lasts one cycle
        start_op(3'b111, 8'd50, 8'd60);
        wait_pronto(lat, busy);
        check("err_lat", lat, 1);
        check("err_erro", erro, 1);
        check("err_saida", saida, 9);
        check("err_flags", {carry, zero, overflow}, 0);
        @(posedge clk);
        #1;
        check("err_pulse_end", {pronto, erro}, 0);
        check("err_saida_hold", saida, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
